// File: rtl/instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq
//
// Instruction fetch / execute sequencer. It owns the program counter, the
// instruction register, the micro-state register handed to the control unit,
// and the registered ALU status flags. A four-state FSM walks through
// FETCH -> (WAIT) -> EXEC ... EXEC -> FETCH, or parks in HALT until reset.
//
// Memory handshake: the sequencer raises mem_req with mem_addr = PC and holds
// both stable until memory answers. A fetch is accepted in exactly the cycle
// where mem_req and mem_valid are both high; mem_data is captured into IR on
// that edge. Memory may keep mem_valid high at any time; it only has an
// effect while mem_req is high.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   mem_addr     out  fetch address (always the current PC)
//   mem_req      out  fetch request, high in FETCH and WAIT
//   mem_valid    in   memory response valid
//   mem_data     in   fetched instruction word
//   IR           out  instruction register
//   state        out  micro-state for the control unit
//   NS           in   next micro-state from the control unit, 0 = done
//   PC_FS        in   PC update select: 00 hold, 01 +4, 10 +k_offset*4, 11 load
//   k_offset     in   sign-extended branch offset in words
//   pc_in        in   absolute PC load value
//   status_load  in   capture status_in while executing
//   status_in    in   ALU flags N,Z,C,V
//   status       out  registered flags
//   halt         in   synchronous stop request
//   exec_en      out  high in EXEC, qualifies datapath writes
//   halted       out  high in HALT
//   o_fsm_state  out  FSM state (0 FETCH, 1 WAIT, 2 EXEC, 3 HALT)
// ----------------------------------------------------------------------------
module instr_fetch_seq #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] PC_RESET = '0
) (
   input  logic            clock,
   input  logic            reset,
   output logic [PC_W-1:0] mem_addr,
   output logic            mem_req,
   input  logic            mem_valid,
   input  logic [31:0]     mem_data,
   output logic [31:0]     IR,
   output logic [3:0]      state,
   input  logic [3:0]      NS,
   input  logic [1:0]      PC_FS,
   input  logic [PC_W-1:0] k_offset,
   input  logic [PC_W-1:0] pc_in,
   input  logic            status_load,
   input  logic [3:0]      status_in,
   output logic [3:0]      status,
   input  logic            halt,
   output logic            exec_en,
   output logic            halted,
   output logic [1:0]      o_fsm_state
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } fsm_t;

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   fsm_t            r_fsm;
   logic [PC_W-1:0] r_pc;
   logic [31:0]     r_ir;
   logic [3:0]      r_state;
   logic [3:0]      r_status;
   // Remembers a halt request seen while a fetch or a multi-cycle instruction
   // was still in flight; honoured when the instruction completes.
   logic            r_halt_pend;

   logic            w_hs;
   logic [PC_W-1:0] w_pc_next;

   // mem_req is a decode of the state register, gated by reset so that it is
   // low while reset is held and rises in the same cycle reset is released.
   assign mem_req     = reset & ((r_fsm == S_FETCH) | (r_fsm == S_WAIT));
   assign w_hs        = mem_req & mem_valid;
   assign mem_addr    = r_pc;
   assign IR          = r_ir;
   assign state       = r_state;
   assign status      = r_status;
   assign exec_en     = (r_fsm == S_EXEC);
   assign halted      = (r_fsm == S_HALT);
   assign o_fsm_state = r_fsm;

   // PC update candidates; all arithmetic wraps modulo 2^PC_W.
   always_comb begin
      w_pc_next = r_pc;
      case (PC_FS)
         2'b00: w_pc_next = r_pc;
         2'b01: w_pc_next = r_pc + PC_STEP;
         2'b10: w_pc_next = r_pc + (k_offset << 2);
         2'b11: w_pc_next = pc_in;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fsm       <= S_FETCH;
         r_pc        <= PC_RESET;
         r_ir        <= 32'd0;
         r_state     <= 4'd0;
         r_status    <= 4'd0;
         r_halt_pend <= 1'b0;
      end else begin
         case (r_fsm)
            S_FETCH: begin
               // A stop request seen here takes effect at once; a response
               // arriving in the same cycle is not captured.
               if (halt) begin
                  r_fsm <= S_HALT;
               end else if (w_hs) begin
                  r_ir    <= mem_data;
                  r_state <= 4'd0;
                  r_fsm   <= S_EXEC;
               end else begin
                  r_fsm <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (halt) begin
                  r_halt_pend <= 1'b1;
               end
               if (w_hs) begin
                  r_ir    <= mem_data;
                  r_state <= 4'd0;
                  r_fsm   <= S_EXEC;
               end
            end

            S_EXEC: begin
               r_state <= NS;
               if (status_load) begin
                  r_status <= status_in;
               end
               if (NS == 4'd0) begin
                  // Instruction completes: the PC update always lands, even
                  // when the sequencer stops afterwards.
                  r_pc        <= w_pc_next;
                  r_halt_pend <= 1'b0;
                  if (halt || r_halt_pend) begin
                     r_fsm <= S_HALT;
                  end else begin
                     r_fsm <= S_FETCH;
                  end
               end else if (halt) begin
                  r_halt_pend <= 1'b1;
               end
            end

            S_HALT: begin
               r_fsm <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

   localparam int PC_W = 64;
   localparam logic [1:0] F_FETCH = 2'd0;
   localparam logic [1:0] F_WAIT  = 2'd1;
   localparam logic [1:0] F_EXEC  = 2'd2;
   localparam logic [1:0] F_HALT  = 2'd3;

   logic            clock = 1'b0;
   logic            reset;
   logic [PC_W-1:0] mem_addr;
   logic            mem_req;
   logic            mem_valid;
   logic [31:0]     mem_data;
   logic [31:0]     IR;
   logic [3:0]      state;
   logic [3:0]      NS;
   logic [1:0]      PC_FS;
   logic [PC_W-1:0] k_offset;
   logic [PC_W-1:0] pc_in;
   logic            status_load;
   logic [3:0]      status_in;
   logic [3:0]      status;
   logic            halt;
   logic            exec_en;
   logic            halted;
   logic [1:0]      o_fsm_state;

   instr_fetch_seq #(.PC_W(PC_W), .PC_RESET('0)) dut (
      .clock(clock), .reset(reset),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_valid(mem_valid), .mem_data(mem_data),
      .IR(IR), .state(state), .NS(NS), .PC_FS(PC_FS),
      .k_offset(k_offset), .pc_in(pc_in),
      .status_load(status_load), .status_in(status_in), .status(status),
      .halt(halt), .exec_en(exec_en), .halted(halted), .o_fsm_state(o_fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [PC_W-1:0] exp_q[$];     // expected fetch addresses
   logic [31:0]     exp_ir_q[$];  // expected IR after each handshake
   logic [PC_W-1:0] m_pc;
   logic [3:0]      m_status;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] data;
      int          wait_cyc;
      int          n_exec;
      logic [15:0] ns_seq;   // NS for EXEC cycle i in bits [4i+3:4i]
      logic [1:0]  pc_fs;
      logic [63:0] k_off;
      logic [63:0] pc_ld;
      logic        st_load;  // status_load in the first EXEC cycle
      logic [3:0]  st_in;
      logic [63:0] exp_pc;
      logic [3:0]  exp_status;
   } vec_t;

   vec_t vecs[9];

   task automatic run_vec(input vec_t v);
      logic [31:0]     ir_before;
      logic [PC_W-1:0] pc_before;
      logic [3:0]      exp_state;
      logic [63:0]     want_addr;
      logic [31:0]     want_ir;
      exp_q.push_back(m_pc);
      exp_ir_q.push_back(v.data);
      ir_before = IR;
      check("start_fsm_fetch", o_fsm_state, F_FETCH);
      mem_data    = v.data;
      mem_valid   = 1'b0;
      // status noise outside EXEC must never be captured
      status_load = 1'b1;
      status_in   = 4'b1010;
      for (int i = 0; i < v.wait_cyc; i++) begin
         check("wait_req", mem_req, 1'b1);
         check("wait_addr", mem_addr, m_pc);
         check("wait_ir", IR, ir_before);
         step();
      end
      mem_valid = 1'b1;
      for (int b = 0; b < 8 && !mem_req; b++) step();
      check("hs_req", mem_req, 1'b1);
      if (exp_q.size() == 0) begin
         check("fetch_q_empty", 1'b1, 1'b0);
      end else begin
         want_addr = exp_q.pop_front();
         check("fetch_addr", mem_addr, want_addr);
      end
      step();
      mem_valid   = 1'b0;
      status_load = 1'b0;
      want_ir = exp_ir_q.pop_front();
      check("ir_load", IR, want_ir);
      check("status_hold_fetch", status, m_status);
      pc_before = m_pc;
      exp_state = 4'd0;
      for (int i = 0; i < v.n_exec; i++) begin
         check("exec_en", exec_en, 1'b1);
         check("exec_state", state, exp_state);
         check("exec_pc_hold", mem_addr, pc_before);
         check("exec_noreq", mem_req, 1'b0);
         NS          = v.ns_seq[4*i +: 4];
         PC_FS       = v.pc_fs;
         k_offset    = v.k_off;
         pc_in       = v.pc_ld;
         status_load = v.st_load && (i == 0);
         status_in   = v.st_in;
         exp_state   = NS;
         step();
      end
      NS = 4'd0; PC_FS = 2'b00; status_load = 1'b0;
      m_pc     = v.exp_pc;
      m_status = v.exp_status;
      check("next_pc", mem_addr, m_pc);
      check("done_exec_off", exec_en, 1'b0);
      check("done_state", state, 4'd0);
      check("done_status", status, m_status);
   endtask

   // reset held across one clock edge, released mid-cycle
   task automatic reset_pulse();
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check("rst_pc", mem_addr, 64'd0);
      check("rst_ir", IR, 32'd0);
      check("rst_status", status, 4'd0);
      check("rst_state", state, 4'd0);
      check("rst_req", mem_req, 1'b0);
      check("rst_exec", exec_en, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_fsm", o_fsm_state, F_FETCH);
      step();
      check("rst_hold_ir", IR, 32'd0);
      check("rst_hold_status", status, 4'd0);
      reset = 1'b1;
      #1;
      check("rel_req", mem_req, 1'b1);
      m_pc = '0;
      m_status = 4'd0;
   endtask

   vec_t hv;

   initial begin
      // table: {data, wait, n_exec, ns_seq, pc_fs, k_off, pc_in, st_load, st_in, exp_pc, exp_status}
      vecs[0] = '{32'h8B020020, 0, 1, 16'h0000, 2'b01, 64'd0, 64'd0, 1'b0, 4'h0, 64'h4, 4'h0};
      vecs[1] = '{32'h11111111, 5, 1, 16'h0000, 2'b00, 64'd0, 64'd0, 1'b0, 4'h0, 64'h4, 4'h0};
      vecs[2] = '{32'h22222222, 0, 3, 16'h0023, 2'b01, 64'd0, 64'd0, 1'b1, 4'b0100, 64'h8, 4'b0100};
      vecs[3] = '{32'h33333333, 1, 1, 16'h0000, 2'b11, 64'd0, 64'h1000, 1'b0, 4'h0, 64'h1000, 4'b0100};
      vecs[4] = '{32'h44444444, 0, 2, 16'h0005, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1, 4'b0001, 64'hFF8, 4'b0001};
      vecs[5] = '{32'h55555555, 2, 1, 16'h0000, 2'b11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0001};
      vecs[6] = '{32'h66666666, 0, 1, 16'h0000, 2'b01, 64'd0, 64'd0, 1'b0, 4'h0, 64'h0, 4'b0001};
      vecs[7] = '{32'h77777777, 0, 1, 16'h0000, 2'b10, 64'd3, 64'd0, 1'b1, 4'b1001, 64'hC, 4'b1001};
      vecs[8] = '{32'h88888888, 3, 4, 16'h01F7, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1001};

      reset = 1'b0; mem_valid = 1'b0; mem_data = 32'd0; NS = 4'd0; PC_FS = 2'b00;
      k_offset = '0; pc_in = '0; status_load = 1'b0; status_in = 4'd0; halt = 1'b0;
      m_pc = '0; m_status = 4'd0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check("init_pc", mem_addr, 64'd0);
      check("init_ir", IR, 32'd0);
      check("init_state", state, 4'd0);
      check("init_status", status, 4'd0);
      check("init_req", mem_req, 1'b0);
      check("init_exec", exec_en, 1'b0);
      check("init_halted", halted, 1'b0);
      reset = 1'b1;
      #1;
      check("init_rel_req", mem_req, 1'b1);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // move PC somewhere distinct from PC_RESET
      hv = '{32'h99999999, 0, 1, 16'h0000, 2'b11, 64'd0, 64'h2000, 1'b0, 4'h0, 64'h2000, 4'b1001};
      run_vec(hv);

      // halt raised in WAIT: fetch finishes, instruction runs, PC updates, then HALT
      mem_valid = 1'b0;
      step();
      check("hw_in_wait", o_fsm_state, F_WAIT);
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("hw_deferred", o_fsm_state, F_WAIT);
      check("hw_req", mem_req, 1'b1);
      step();
      mem_valid = 1'b1; mem_data = 32'hAAAA0000;
      step();
      mem_valid = 1'b0;
      check("hw_exec", exec_en, 1'b1);
      check("hw_ir", IR, 32'hAAAA0000);
      NS = 4'd0; PC_FS = 2'b01;
      step();
      PC_FS = 2'b00;
      check("hw_halted", halted, 1'b1);
      check("hw_noreq", mem_req, 1'b0);
      check("hw_noexec", exec_en, 1'b0);
      check("hw_pc", mem_addr, 64'h2004);
      mem_valid = 1'b1; mem_data = 32'h12345678;
      repeat (3) step();
      mem_valid = 1'b0;
      check("hw_terminal", halted, 1'b1);
      check("hw_ir_frozen", IR, 32'hAAAA0000);
      reset_pulse();

      // halt raised in EXEC with NS!=0: deferred until completion
      mem_valid = 1'b1; mem_data = 32'hBBBB0000;
      step();
      mem_valid = 1'b0;
      halt = 1'b1; NS = 4'd4; PC_FS = 2'b01;
      step();
      halt = 1'b0;
      check("he_still_exec", exec_en, 1'b1);
      check("he_state", state, 4'd4);
      NS = 4'd0;
      step();
      PC_FS = 2'b00;
      check("he_halted", halted, 1'b1);
      check("he_pc", mem_addr, 64'h4);
      reset_pulse();

      // halt raised in FETCH: immediate stop, PC and IR untouched
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("hf_halted", halted, 1'b1);
      check("hf_pc", mem_addr, 64'h0);
      check("hf_ir", IR, 32'h0);
      check("hf_noreq", mem_req, 1'b0);
      reset_pulse();

      // reset mid-EXEC: status load in that cycle is discarded
      mem_valid = 1'b1; mem_data = 32'hDDDD0000;
      step();
      mem_valid = 1'b0;
      check("rx_ir", IR, 32'hDDDD0000);
      NS = 4'd2; PC_FS = 2'b01; status_load = 1'b1; status_in = 4'b0110;
      #2 reset = 1'b0;
      #1;
      check("rx_ir_clr", IR, 32'h0);
      check("rx_status_clr", status, 4'h0);
      check("rx_exec_off", exec_en, 1'b0);
      step();
      check("rx_status_hold", status, 4'h0);
      check("rx_state_hold", state, 4'h0);
      reset = 1'b1;
      #1;
      status_load = 1'b0; NS = 4'd0; PC_FS = 2'b00;
      check("rx_fetch", o_fsm_state, F_FETCH);
      check("rx_pc", mem_addr, 64'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 Parameter PC_W, default 64, is the program-counter and memory-address width.
REQ-002 Parameter PC_RESET, default 0, is the PC value loaded at reset.
REQ-003 clock  input  1  is the single clock; every register updates on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-low reset; all state is cleared while it is low.
REQ-005 mem_addr  output  PC_W  is the instruction fetch address.
REQ-006 mem_req  output  1  is the fetch request, held high until accepted.
REQ-007 mem_valid  input  1  marks mem_data valid; a fetch is accepted in the cycle where mem_req and mem_valid are both high.
REQ-008 mem_data  input  32  is the fetched instruction word.
REQ-009 IR  output  32  is the instruction register, fed to the control unit.
REQ-010 state  output  4  is the micro-state, fed to the control unit.
REQ-011 NS  input  4  is the next micro-state from the control unit; 0 means the instruction is complete.
REQ-012 PC_FS  input  2  selects the PC update: 00 hold, 01 PC+4, 10 PC+(k_offset<<2), 11 load pc_in.
REQ-013 k_offset  input  PC_W  is the sign-extended branch offset, counted in words.
REQ-014 pc_in  input  PC_W  is the absolute PC load value.
REQ-015 status_load  input  1  enables capture of status_in into status.
REQ-016 status_in  input  4  carries the ALU flags N,Z,C,V.
REQ-017 status  output  4  is the registered flags, fed to the control unit.
REQ-018 halt  input  1  is a synchronous stop request.
REQ-019 exec_en  output  1  is high only in EXEC and qualifies datapath writes.
REQ-020 halted  output  1  is high in HALT.

Function
REQ-021 The FSM SHALL have 4 states: FETCH, WAIT, EXEC, HALT.
REQ-022 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal PC; the FSM moves to WAIT on the next cycle if mem_valid is not high in FETCH.
REQ-023 A handshake (mem_req & mem_valid) in FETCH or WAIT SHALL load IR from mem_data, set state to 0, and move to EXEC on the next cycle; fetch latency is 1 cycle minimum.
REQ-024 In WAIT, mem_req SHALL stay 1 and mem_addr SHALL stay stable until the handshake; there is no timeout.
REQ-025 In EXEC, each cycle SHALL apply state<=NS and assert exec_en.
REQ-026 In EXEC with NS==0, the FSM SHALL apply the PC update selected by PC_FS in that same cycle and return to FETCH.
REQ-027 In EXEC with NS!=0, the PC SHALL hold.
REQ-028 PC arithmetic SHALL be modulo 2^PC_W; wrap-around is silent.
REQ-029 status SHALL load status_in on any cycle where exec_en and status_load are both high; otherwise status holds.
REQ-030 IR SHALL change only on a fetch handshake.
REQ-031 halt sampled high in FETCH or at instruction completion SHALL move the FSM to HALT, with the completing PC update still applied.
REQ-032 halt sampled high in WAIT SHALL be deferred until the outstanding fetch completes.
REQ-033 halt sampled high in EXEC with NS!=0 SHALL be deferred until the instruction completes.
REQ-034 HALT SHALL be terminal until reset, with mem_req=0 and exec_en=0.
REQ-035 A single-state instruction (NS==0 on its first EXEC cycle) SHALL take 1 EXEC cycle, giving a 2-cycle instruction minimum.

Reset
REQ-036 While reset is low: PC=PC_RESET, IR=0, state=0, status=0, FSM=FETCH, mem_req=0, exec_en=0, halted=0.
REQ-037 mem_req SHALL assert in the first cycle after reset deasserts.
REQ-038 Reset asserted mid-fetch or mid-EXEC SHALL abort immediately, discard any pending handshake, and leave IR and status unchanged by that cycle.

Verification
REQ-039 Reset release, mem_valid=1, mem_data=0x8B020020, NS=0, PC_FS=01 -> IR=0x8B020020 after 1 cycle, exec_en for 1 cycle, PC 0->4, next fetch at 4.
REQ-040 mem_valid held low 5 cycles in WAIT -> mem_req=1 and mem_addr stable for all 5 cycles, IR unchanged until the handshake.
REQ-041 Multi-state sequence NS=3,2,0 -> state follows 0,3,2; PC changes only on the third EXEC cycle.
REQ-042 PC=0x1000, PC_FS=10, k_offset=-2 -> PC=0xFF8; PC=2^64-4, PC_FS=01 -> PC=0.
REQ-043 status_load=1, status_in=4'b0100 in EXEC -> status=4'b0100; same stimulus in WAIT -> status unchanged.
REQ-044 halt raised in WAIT -> fetch completes, instruction executes, PC updates, then halted=1 and mem_req=0; a later reset pulse restores PC=PC_RESET.
